// File: rtl/vrased_pkg.sv
// Shared types and bit-index constants for the VRASED region monitor.
package vrased_pkg;

    typedef enum logic {ST_RUN, ST_KILL} state_e;

    localparam int unsigned MODE_RD      = 0;
    localparam int unsigned MODE_WR      = 1;
    localparam int unsigned MODE_DMA     = 2;
    localparam int unsigned MODE_SMEM_OK = 3;

    // Offsets above the per-region cause bits.
    localparam int unsigned CAUSE_ATOM     = 0;
    localparam int unsigned CAUSE_IRQ      = 1;
    localparam int unsigned CAUSE_DMA_SMEM = 2;
    localparam int unsigned CAUSE_EXTRA    = 3;

endpackage

// File: rtl/vrased_range_check.sv
// Inclusive range test base <= addr <= base+size, evaluated one bit wider so the
// upper bound never wraps; oversized regions clamp to the top of the address space.
module vrased_range_check #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] size_i,
    output logic              hit_o
);

    logic [ADDR_W:0] top;

    always_comb begin
        top   = {1'b0, base_i} + {1'b0, size_i};
        hit_o = ({1'b0, addr_i} >= {1'b0, base_i}) && ({1'b0, addr_i} <= top);
    end

endmodule

// File: rtl/vrased_region_monitor.sv
// VRASED region monitor: per-region CPU/DMA protection plus SMEM atomicity, sticky kill
// state driving the MCU reset. Define VRASED_VIOL_LOG_EN to implement the violation log.
module vrased_region_monitor
    import vrased_pkg::*;
#(
    parameter int unsigned                   ADDR_W        = 16,
    parameter int unsigned                   NUM_REGIONS   = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE   = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE   = '0,
    parameter logic [NUM_REGIONS*4-1:0]      REGION_MODE   = '0,
    parameter logic [ADDR_W-1:0]             SMEM_BASE     = 16'hA100,
    parameter logic [ADDR_W-1:0]             SMEM_SIZE     = 16'h1EFE,
    parameter logic [ADDR_W-1:0]             RESET_HANDLER = 16'h0000,
    parameter int unsigned                   CNT_W         = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        pc,
    input  logic                     data_en,
    input  logic                     data_wr,
    input  logic [ADDR_W-1:0]        data_addr,
    input  logic                     dma_en,
    input  logic [ADDR_W-1:0]        dma_addr,
    input  logic                     irq,
    output logic                     viol_reset,
    output logic [NUM_REGIONS+2:0]   viol_cause,
    output logic [ADDR_W-1:0]        viol_addr,
    output logic [CNT_W-1:0]         viol_count
);

    localparam int unsigned CW = NUM_REGIONS + CAUSE_EXTRA;
    localparam logic [ADDR_W-1:0] SMEM_LAST = SMEM_BASE + SMEM_SIZE;

    logic [NUM_REGIONS-1:0] cpu_in, dma_in, cpu_hit, dma_hit;
    logic                   pc_in_smem, prev_in_smem;
    logic                   atom_entry, atom_exit;
    logic [CW-1:0]          cause_now;
    logic                   viol_now;

    state_e            state_q, state_d;
    logic              viol_reset_q, viol_reset_d;
    logic [ADDR_W-1:0] prev_pc_q, prev_pc_d;

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
        localparam logic [3:0] Mode = REGION_MODE[i*4 +: 4];

        vrased_range_check #(.ADDR_W(ADDR_W)) u_cpu (
            .addr_i (data_addr),
            .base_i (REGION_BASE[i*ADDR_W +: ADDR_W]),
            .size_i (REGION_SIZE[i*ADDR_W +: ADDR_W]),
            .hit_o  (cpu_in[i])
        );

        vrased_range_check #(.ADDR_W(ADDR_W)) u_dma (
            .addr_i (dma_addr),
            .base_i (REGION_BASE[i*ADDR_W +: ADDR_W]),
            .size_i (REGION_SIZE[i*ADDR_W +: ADDR_W]),
            .hit_o  (dma_in[i])
        );

        // SMEM code may be trusted with CPU accesses, never with DMA.
        assign cpu_hit[i] = data_en && cpu_in[i]
                            && ((!data_wr && Mode[MODE_RD]) || (data_wr && Mode[MODE_WR]))
                            && !(Mode[MODE_SMEM_OK] && pc_in_smem);
        assign dma_hit[i] = dma_en && dma_in[i] && Mode[MODE_DMA];
    end

    vrased_range_check #(.ADDR_W(ADDR_W)) u_smem_pc (
        .addr_i (pc),
        .base_i (SMEM_BASE),
        .size_i (SMEM_SIZE),
        .hit_o  (pc_in_smem)
    );

    vrased_range_check #(.ADDR_W(ADDR_W)) u_smem_prev (
        .addr_i (prev_pc_q),
        .base_i (SMEM_BASE),
        .size_i (SMEM_SIZE),
        .hit_o  (prev_in_smem)
    );

    always_comb begin
        atom_entry = pc_in_smem && !prev_in_smem && (pc != SMEM_BASE);
        atom_exit  = prev_in_smem && !pc_in_smem && (prev_pc_q != SMEM_LAST);
        cause_now  = '0;
        cause_now[NUM_REGIONS-1:0]              = cpu_hit | dma_hit;
        cause_now[NUM_REGIONS + CAUSE_ATOM]     = atom_entry || atom_exit;
        cause_now[NUM_REGIONS + CAUSE_IRQ]      = irq && pc_in_smem;
        cause_now[NUM_REGIONS + CAUSE_DMA_SMEM] = dma_en && pc_in_smem;
        viol_now   = |cause_now;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (viol_now) state_d = ST_KILL;
            ST_KILL: if (pc == RESET_HANDLER) state_d = ST_RUN;
        endcase
        viol_reset_d = (state_d == ST_KILL);
        prev_pc_d    = pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            viol_reset_q <= 1'b0;
            prev_pc_q    <= RESET_HANDLER;
        end else begin
            state_q      <= state_d;
            viol_reset_q <= viol_reset_d;
            prev_pc_q    <= prev_pc_d;
        end
    end

    assign viol_reset = viol_reset_q;

`ifdef VRASED_VIOL_LOG_EN
    logic              log_en;
    logic [CW-1:0]     cause_q, cause_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        log_en  = (state_q == ST_RUN) && viol_now;
        cause_d = cause_q;
        addr_d  = addr_q;
        count_d = count_q;
        if (log_en) begin
            cause_d = cause_now;
            if (|cpu_hit)      addr_d = data_addr;
            else if (|dma_hit) addr_d = dma_addr;
            else               addr_d = pc;
            if (count_q != '1) count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause_q <= '0;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            cause_q <= cause_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    assign viol_cause = cause_q;
    assign viol_addr  = addr_q;
    assign viol_count = count_q;
`else
    assign viol_cause = '0;
    assign viol_addr  = '0;
    assign viol_count = '0;
`endif

endmodule
